// File: rtl/pipeline_buffer_param.sv
// pipeline_buffer_param: DEPTH-stage elastic valid/ready pipeline with bubble collapsing.
// Defining PIPE_FLUSH_EN adds a synchronous flush input that empties the buffer.
module pipeline_buffer_param #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ip,
    input  logic             ip_valid,
    output logic             ip_ready,
    output logic [WIDTH-1:0] op,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [CW-1:0]    count
`ifdef PIPE_FLUSH_EN
    ,
    input  logic             flush
`endif
);
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic             fl;
    logic             run;
    logic             take;
    logic             give;

`ifdef PIPE_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif

    // A stage may advance if it or any stage downstream of it is empty, or the sink takes a word
    always_comb begin
        run = op_ready;
        adv = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            run    = run | !vld[k];
            adv[k] = run;
        end
    end

    assign ip_ready = adv[0] & !fl;
    assign op       = dat[DEPTH-1];
    assign op_valid = vld[DEPTH-1];
    assign take     = ip_valid & ip_ready;
    assign give     = op_valid & op_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld   <= '0;
            count <= '0;
            for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
        end else if (fl) begin
            vld   <= '0;
            count <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) dat[k] <= dat[k-1];
                end
            end
            if (adv[0]) begin
                vld[0] <= ip_valid;
                if (ip_valid) dat[0] <= ip;
            end
            count <= count + CW'(take) - CW'(give);
        end
    end
endmodule

// File: tb/tb_pipeline_buffer_param.sv
// tb_pipeline_buffer_param: randomized and directed checks of pipeline_buffer_param
// against a queue-of-words model where each word becomes visible DEPTH edges after acceptance.
module tb_pipeline_buffer_param;
    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] ip = '0;
    logic             ip_valid = 1'b0;
    logic             op_ready = 1'b0;
    logic             fl = 1'b0;
    logic             ip_ready;
    logic [WIDTH-1:0] op;
    logic             op_valid;
    logic [CW-1:0]    count;

    pipeline_buffer_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ip(ip), .ip_valid(ip_valid), .ip_ready(ip_ready),
        .op(op), .op_valid(op_valid), .op_ready(op_ready), .count(count)
`ifdef PIPE_FLUSH_EN
        , .flush(fl)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mq_d[$];
    int mq_age[$];
    int outlog[$];
    bit took;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare against the model at negedge, advance the model
    task automatic cycle(input bit vi, input int d, input bit rdy, input bit f);
        bit er, ev, out;
        ip_valid = vi;
        ip = d[WIDTH-1:0];
        op_ready = rdy;
        fl = f;
        @(negedge clk);
        er = (mq_d.size() < DEPTH || rdy) && !f;
        ev = mq_d.size() > 0 && mq_age[0] >= DEPTH;
        chk("ip_ready", int'(ip_ready), int'(er));
        chk("op_valid", int'(op_valid), int'(ev));
        chk("count", int'(count), mq_d.size());
        if (ev) chk("op", int'(op), mq_d[0]);
        took = vi && er;
        out = ev && rdy;
        if (out) begin
            outlog.push_back(mq_d[0]);
            void'(mq_d.pop_front());
            void'(mq_age.pop_front());
        end
        foreach (mq_age[i]) mq_age[i]++;
        if (f) begin
            mq_d.delete();
            mq_age.delete();
        end
        if (took) begin
            mq_d.push_back(d % (1 << WIDTH));
            mq_age.push_back(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && mq_d.size() > 0; i++) cycle(0, 0, 1, 0);
        chk("drain_count", int'(count), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w2[8] = '{1, 0, 2, 3, 1, 1, 1, 1};
        int e2[4] = '{1, 0, 2, 3};
        int w3[6] = '{1, 2, 3, 0, 1, 2};
        int j;
        bit pend;
        int pd;
        bit vi;
        int d;
        bit rdy;
        bit f;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // async reset with three words inside, taken mid-clock
        cycle(1, 1, 0, 0);
        cycle(1, 2, 0, 0);
        cycle(1, 3, 0, 0);
        cycle(0, 0, 0, 0);
        chk("t1_count_pre", int'(count), 3);
        chk("t1_opv_pre", int'(op_valid), 1);
        chk("t1_op_pre", int'(op), 1);
        #2 rst = 1'b0;
        #1;
        chk("t1_op_rst", int'(op), 0);
        chk("t1_opv_rst", int'(op_valid), 0);
        chk("t1_count_rst", int'(count), 0);
        mq_d.delete();
        mq_age.delete();
        #2 rst = 1'b1;
        #1;
        chk("t1_ready_rel", int'(ip_ready), 1);
        @(posedge clk);
        #1;

        // streaming with op_ready=1
        outlog.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(1, w2[i], 1, 0);
            if (i >= 3 && i <= 6) begin
                chk("t2_op", int'(op), e2[i-3]);
                chk("t2_opv", int'(op_valid), 1);
                chk("t2_count", int'(count), 4);
            end
        end
        drain();

        // backpressure then release
        outlog.delete();
        j = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(j < 6, j < 6 ? w3[j] : 0, 0, 0);
            if (took) j++;
        end
        chk("t3_count", int'(count), 4);
        chk("t3_op", int'(op), 1);
        chk("t3_opv", int'(op_valid), 1);
        chk("t3_ready", int'(ip_ready), 0);
        for (int i = 0; i < 30 && (j < 6 || mq_d.size() > 0); i++) begin
            cycle(j < 6, j < 6 ? w3[j] : 0, 1, 0);
            if (took) j++;
        end
        chk("t3_nout", outlog.size(), 6);
        for (int i = 0; i < 6 && i < outlog.size(); i++) chk("t3_order", outlog[i], w3[i]);

        // lone word collapses through bubbles while stalled
        cycle(1, 3, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("t4_opv_early", int'(op_valid), 0);
        cycle(0, 0, 0, 0);
        chk("t4_opv", int'(op_valid), 1);
        chk("t4_op", int'(op), 3);
        chk("t4_count", int'(count), 1);
        chk("t4_ready", int'(ip_ready), 1);

        // full with simultaneous in/out
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        chk("t5_full", int'(count), 4);
        outlog.delete();
        cycle(1, 2, 1, 0);
        chk("t5_count", int'(count), 4);
        drain();
        chk("t5_nout", outlog.size(), 5);
        if (outlog.size() == 5) chk("t5_fourth", outlog[4], 2);

`ifdef PIPE_FLUSH_EN
        cycle(1, 1, 0, 0);
        cycle(1, 2, 0, 0);
        cycle(1, 3, 0, 0);
        cycle(1, 3, 0, 1);
        chk("t6_count", int'(count), 0);
        chk("t6_opv", int'(op_valid), 0);
        cycle(1, 2, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("t6_opv_early", int'(op_valid), 0);
        cycle(0, 0, 1, 0);
        chk("t6_opv", int'(op_valid), 1);
        chk("t6_op", int'(op), 2);
        drain();
`endif

        // random traffic with upstream holding refused words
        pend = 0;
        pd = 0;
        for (int i = 0; i < 3000; i++) begin
            vi = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            d = pend ? pd : int'($urandom_range(0, 3));
            rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            f = 1'b0;
`ifdef PIPE_FLUSH_EN
            f = ($urandom_range(0, 49) == 0);
`endif
            cycle(vi, d, rdy, f);
            pend = vi && !took && !f;
            pd = d;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
